// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;
  localparam int          MAX_REGS         = 64;
  localparam int          IDX_W            = $clog2(MAX_REGS);

  typedef enum logic [1:0] {
    ERR_NONE,
    MISALIGN,
    RANGE,
    RO_WRITE
  } err_cause_e;

  // First matching cause wins; only used to cross-check pslverr.
  function automatic err_cause_e err_cause(input logic misalign,
                                           input logic out_of_range,
                                           input logic ro_write);
    if (misalign)          return MISALIGN;
    else if (out_of_range) return RANGE;
    else if (ro_write)     return RO_WRITE;
    else                   return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB completer-side bus bundle; pstrb exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_regfile_if;
  import apb_slave_pkg::*;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb;
`endif

  modport master (
`ifdef APB_SLV_PSTRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
`ifdef APB_SLV_PSTRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slv_regbank.sv
// Register storage: reg 0 is the constant ID, regs 1..NUM_REGS-1 are byte-writable.
module apb_slv_regbank
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  localparam int BW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0] word_w [NUM_REGS];

  assign word_w[0] = ID_VALUE;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] reg_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else if (we_i && widx_i == IDX_W'(gi)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) reg_q[8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end

      assign word_w[gi] = reg_q;
    end
  endgenerate

  // Guard keeps non-power-of-two banks from indexing past the array.
  assign rdata_o = (32'(ridx_i) < 32'(NUM_REGS)) ? word_w[ridx_i[BW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with wait-state insertion and error decode over apb_slv_regbank.
// Optional byte strobes: define APB_SLV_PSTRB_EN.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                hclk,
  input  logic                hreset,
  apb_slave_regfile_if.slave  bus
);

  apb_state_e       state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic             err_q;
  logic [31:0]      wdata_q;
  logic [3:0]       strb_q;
  logic             pready_q;
  logic             pslverr_q;
  logic [31:0]      prdata_q;
  err_cause_e       cause_q;

  logic [29:0]      word_d;
  logic             misalign_d, range_d, ro_d, strb_err_d, err_d;
  logic [3:0]       strb_d;
  err_cause_e       cause_d;
  logic [IDX_W-1:0] ridx;
  logic             rd_zero;
  logic             we;
  logic [31:0]      rdata;

  always_comb begin
    word_d     = bus.paddr[31:2];
    misalign_d = bus.paddr[1:0] != 2'b00;
    range_d    = word_d >= 30'(NUM_REGS);
    ro_d       = bus.pwrite && (word_d == '0);
`ifdef APB_SLV_PSTRB_EN
    strb_d     = bus.pstrb;
    strb_err_d = !bus.pwrite && (bus.pstrb != 4'b0000);
`else
    strb_d     = 4'hF;
    strb_err_d = 1'b0;
`endif
    cause_d    = err_cause(misalign_d, range_d, ro_d);
    err_d      = misalign_d || range_d || ro_d || strb_err_d;
    // Zero-wait reads are served from the live bus at the setup edge.
    ridx       = (state_q == IDLE) ? bus.paddr[2 +: IDX_W] : idx_q;
    rd_zero    = (state_q == IDLE) ? (err_d || bus.pwrite) : (err_q || write_q);
    we         = (state_q == ACCESS) && pready_q && bus.psel && write_q && !err_q;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      cause_q   <= ERR_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            state_q <= ACCESS;
            idx_q   <= bus.paddr[2 +: IDX_W];
            write_q <= bus.pwrite;
            err_q   <= err_d;
            cause_q <= cause_d;
            wdata_q <= bus.pwdata;
            strb_q  <= strb_d;
            cnt_q   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rd_zero ? 32'h0 : rdata;
            end
          end
        end
        ACCESS: begin
          if (!bus.psel || pready_q) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            cnt_q     <= '0;
          end else if (bus.penable) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= rd_zero ? 32'h0 : rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_slv_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk     (hclk),
    .rst     (hreset),
    .we_i    (we),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (ridx),
    .rdata_o (rdata)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

  a_err_only_on_ready: assert property (@(posedge hclk) disable iff (hreset)
    bus.pslverr |-> bus.pready);
  a_cause_flags_err: assert property (@(posedge hclk) disable iff (hreset)
    (bus.pready && cause_q != ERR_NONE) |-> bus.pslverr);

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states) behind one shared driver.
module tb_apb_slave_regfile;

  localparam int          WS_A = 0;
  localparam int          WS_B = 3;
  localparam logic [31:0] ID   = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb;
`endif

  apb_slave_regfile_if bus_a ();
  apb_slave_regfile_if bus_b ();

  assign bus_a.psel    = psel & ~sel;
  assign bus_a.penable = penable;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.paddr   = paddr;
  assign bus_a.pwdata  = pwdata;
  assign bus_b.psel    = psel & sel;
  assign bus_b.penable = penable;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwdata  = pwdata;
`ifdef APB_SLV_PSTRB_EN
  assign bus_a.pstrb   = pstrb;
  assign bus_b.pstrb   = pstrb;
`endif

  wire [31:0] prdata  = sel ? bus_b.prdata  : bus_a.prdata;
  wire        pready  = sel ? bus_b.pready  : bus_a.pready;
  wire        pslverr = sel ? bus_b.pslverr : bus_a.pslverr;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(WS_A), .ID_VALUE(ID)) dut_a (
    .hclk   (clk),
    .hreset (rst),
    .bus    (bus_a.slave)
  );

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(WS_B), .ID_VALUE(ID)) dut_b (
    .hclk   (clk),
    .hreset (rst),
    .bus    (bus_b.slave)
  );

  typedef struct {
    string       name;
    logic        sel;
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic s, input logic w,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] er,
                              input logic ee);
    vec_t v;
    v.name = name; v.sel = s; v.w = w; v.addr = addr; v.data = data;
    v.strb = strb; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // One full APB transfer; expectation queued at setup, popped when pready appears.
  task automatic xfer(input vec_t v);
    exp_t e;
    int   n;
    e.name   = v.name;
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    e.cycles = (v.sel ? WS_B : WS_A) + 1;
    sb_q.push_back(e);
    @(negedge clk);
    sel = v.sel; psel = 1'b1; penable = 1'b0; pwrite = v.w;
    paddr = v.addr; pwdata = v.data;
`ifdef APB_SLV_PSTRB_EN
    pstrb = v.strb;
`endif
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    while (pready !== 1'b1 && n < 40) begin
      pwdata = ~v.data;
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    if (pready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: pready never rose within %0d cycles", e.name, n);
    end else begin
      check({e.name, " prdata"}, prdata, e.rdata);
      check({e.name, " pslverr"}, 32'(pslverr), 32'(e.err));
      check({e.name, " latency"}, 32'(n), 32'(e.cycles));
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    check({e.name, " pready_clear"}, 32'(pready), 32'd0);
    $display("[TB] %-14s dut=%0d %s addr=%h rdata=%h err=%0d cycles=%0d",
             e.name, v.sel, v.w ? "WR" : "RD", v.addr, prdata, pslverr, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
`ifdef APB_SLV_PSTRB_EN
    pstrb = 4'h0;
`endif
    repeat (3) @(negedge clk);
    check("reset_a prdata", bus_a.prdata, 32'h0);
    check("reset_a flags", {30'b0, bus_a.pready, bus_a.pslverr}, 32'h0);
    check("reset_b prdata", bus_b.prdata, 32'h0);
    check("reset_b flags", {30'b0, bus_b.pready, bus_b.pslverr}, 32'h0);
    rst = 1'b0;

    // Abort: write to reg 2 on the wait-state instance, psel dropped mid-wait.
    @(negedge clk);
    sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h08; pwdata = 32'h1111_1111;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready !== 1'b0) seen = 1'b1;
    end
    check("abort pready_seen", 32'(seen), 32'd0);
    xfer(mk("abort_rd08", 1, 0, 32'h08, 0, 4'h0, 32'h0, 0));

    // Reset during the wait states of a write to reg 3.
    xfer(mk("rd_id_b", 1, 0, 32'h00, 0, 4'h0, ID, 0));
    @(negedge clk);
    sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'h0BAD_F00D;
`ifdef APB_SLV_PSTRB_EN
    pstrb = 4'hF;
`endif
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("midrst prdata_hold", prdata, ID);
    rst = 1'b1;
    #1;
    check("midrst prdata", prdata, 32'h0);
    check("midrst flags", {30'b0, pready, pslverr}, 32'h0);
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(mk("midrst_rd0C", 1, 0, 32'h0C, 0, 4'h0, 32'h0, 0));

    // Main table: name, dut, write, addr, wdata, strb, expected prdata, expected pslverr.
    vecs.push_back(mk("wr04_dead",   0, 1, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 0));
    vecs.push_back(mk("rd04",        0, 0, 32'h04, 32'h0,         4'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("rd00_ws3",    1, 0, 32'h00, 32'h0,         4'h0, ID, 0));
    vecs.push_back(mk("wr00_ro",     1, 1, 32'h00, 32'h1234_5678, 4'hF, 32'h0, 1));
    vecs.push_back(mk("wr20_range",  1, 1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1));
    vecs.push_back(mk("wr06_align",  1, 1, 32'h06, 32'h1234_5678, 4'hF, 32'h0, 1));
    vecs.push_back(mk("rd00_after",  1, 0, 32'h00, 32'h0,         4'h0, ID, 0));
    vecs.push_back(mk("rd04_after",  1, 0, 32'h04, 32'h0,         4'h0, 32'h0, 0));
    vecs.push_back(mk("rd20_range",  0, 0, 32'h20, 32'h0,         4'h0, 32'h0, 1));
    vecs.push_back(mk("rd03_align",  0, 0, 32'h03, 32'h0,         4'h0, 32'h0, 1));
    vecs.push_back(mk("wr_hi_range", 0, 1, 32'h8000_0004, 32'h0,  4'hF, 32'h0, 1));
    vecs.push_back(mk("rd04_kept",   0, 0, 32'h04, 32'h0,         4'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk("wr1C_top",    0, 1, 32'h1C, 32'h5555_AAAA, 4'hF, 32'h0, 0));
    vecs.push_back(mk("rd1C_top",    0, 0, 32'h1C, 32'h0,         4'h0, 32'h5555_AAAA, 0));
    vecs.push_back(mk("wr08_ws3",    1, 1, 32'h08, 32'hCAFE_F00D, 4'hF, 32'h0, 0));
    vecs.push_back(mk("rd08_ws3",    1, 0, 32'h08, 32'h0,         4'h0, 32'hCAFE_F00D, 0));
    vecs.push_back(mk("rd00_id_a",   0, 0, 32'h00, 32'h0,         4'h0, ID, 0));
    foreach (vecs[i]) xfer(vecs[i]);

`ifdef APB_SLV_PSTRB_EN
    xfer(mk("strb_preload", 0, 1, 32'h04, 32'hFFFF_FFFF, 4'hF,    32'h0, 0));
    xfer(mk("strb_0101",    0, 1, 32'h04, 32'h0000_0000, 4'b0101, 32'h0, 0));
    xfer(mk("strb_rd",      0, 0, 32'h04, 32'h0,         4'h0,    32'hFF00_FF00, 0));
    xfer(mk("strb_noop",    0, 1, 32'h04, 32'h0,         4'h0,    32'h0, 0));
    xfer(mk("strb_rd2",     0, 0, 32'h04, 32'h0,         4'h0,    32'hFF00_FF00, 0));
    xfer(mk("strb_bad_rd",  0, 0, 32'h04, 32'h0,         4'h1,    32'h0, 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
